// File: rtl/ysyx_25040111_exu.sv
// Execute unit: latches one decoded op, drives an external combinational ALU
// from the latched op, captures the writeback result and pulses a fetch
// redirect for taken branches and jumps. States: IDLE -> EXEC -> HOLD.
// Optional performance counters are enabled by defining YSYX_25040111_EXU_PERF_EN.
module ysyx_25040111_exu (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [1:0]  in_src1_sel,
    input  logic        in_src2_sel,
    input  logic [2:0]  in_opt,
    input  logic        in_snpc,
    input  logic        in_ext,
    input  logic        in_sign,
    input  logic        in_negate,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_var1,
    output logic [31:0] alu_var2,
    output logic [2:0]  alu_opt,
    output logic        alu_snpc,
    output logic        alu_ext,
    output logic        alu_sign,
    output logic        alu_negate,
    input  logic [31:0] alu_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
`ifdef YSYX_25040111_EXU_PERF_EN
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall,
`endif
    output logic        redir_valid,
    output logic [31:0] redir_pc
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
    typedef enum logic [1:0] {K_ALU, K_BRANCH, K_JAL, K_JALR} kind_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [1:0]  src1_sel;
        logic        src2_sel;
        logic [2:0]  opt;
        logic        snpc;
        logic        ext;
        logic        sign;
        logic        negate;
        kind_e       kind;
        logic [4:0]  rd;
    } op_t;

    state_e      state_q, state_d;
    op_t         op_q, op_d, in_op;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] tgt_base, tgt_sum;

    // Pack the decode-side fields into one op record
    always_comb begin
        in_op = '{pc: in_pc, rs1: in_rs1, rs2: in_rs2, imm: in_imm,
                  src1_sel: in_src1_sel, src2_sel: in_src2_sel, opt: in_opt,
                  snpc: in_snpc, ext: in_ext, sign: in_sign, negate: in_negate,
                  kind: kind_e'(in_kind), rd: in_rd};
    end

    // FSM next state, handshake and result capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = HOLD;
                if (op_q.kind == K_BRANCH) begin
                    out_rd_d   = '0;
                    out_data_d = '0;
                end else begin
                    out_rd_d   = op_q.rd;
                    out_data_d = alu_res;
                end
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        op_d    = in_op;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operands come only from the latched op
    always_comb begin
        case (op_q.src1_sel)
            2'd0:    alu_var1 = op_q.rs1;
            2'd1:    alu_var1 = op_q.pc;
            default: alu_var1 = '0;
        endcase
        alu_var2   = op_q.src2_sel ? op_q.imm : op_q.rs2;
        alu_opt    = op_q.opt;
        alu_snpc   = op_q.snpc;
        alu_ext    = op_q.ext;
        alu_sign   = op_q.sign;
        alu_negate = op_q.negate;
    end

    // Redirect target from a dedicated adder; jalr clears bit 0
    always_comb begin
        tgt_base = (op_q.kind == K_JALR) ? op_q.rs1 : op_q.pc;
        tgt_sum  = tgt_base + op_q.imm;
        redir_pc = (op_q.kind == K_JALR) ? {tgt_sum[31:1], 1'b0} : tgt_sum;
        redir_valid = 1'b0;
        if (state_q == EXEC) begin
            case (op_q.kind)
                K_BRANCH: redir_valid = alu_res[0];
                K_JAL,
                K_JALR:   redir_valid = 1'b1;
                default:  redir_valid = 1'b0;
            endcase
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;

    // State, op and output registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef YSYX_25040111_EXU_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

    // Count completed writeback handshakes and back-pressured HOLD cycles
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (state_q == HOLD) begin
            if (out_ready) perf_ops_d   = perf_ops_q + 32'd1;
            else           perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25040111_exu.sv
// Self-checking bench for ysyx_25040111_exu: directed vector table,
// backpressure and reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_ysyx_25040111_exu;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [1:0]  in_src1_sel;
    logic        in_src2_sel;
    logic [2:0]  in_opt;
    logic        in_snpc, in_ext, in_sign, in_negate;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] alu_var1, alu_var2, alu_res;
    logic [2:0]  alu_opt;
    logic        alu_snpc, alu_ext, alu_sign, alu_negate;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
`ifdef YSYX_25040111_EXU_PERF_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    always #5 clock = ~clock;

    ysyx_25040111_exu dut (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel), .in_opt(in_opt),
        .in_snpc(in_snpc), .in_ext(in_ext), .in_sign(in_sign), .in_negate(in_negate),
        .in_kind(in_kind), .in_rd(in_rd),
        .alu_var1(alu_var1), .alu_var2(alu_var2), .alu_opt(alu_opt),
        .alu_snpc(alu_snpc), .alu_ext(alu_ext), .alu_sign(alu_sign), .alu_negate(alu_negate),
        .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
`ifdef YSYX_25040111_EXU_PERF_EN
        .perf_ops(perf_ops), .perf_stall(perf_stall),
`endif
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    // Simple stand-in ALU: snpc gives var1+4, 001 add/sub, 111 equality, else xor
    function automatic logic [31:0] tb_alu(input logic [31:0] v1, input logic [31:0] v2,
                                           input logic [2:0] opt, input logic snpc, input logic neg);
        if (snpc) return v1 + 32'd4;
        case (opt)
            3'b001:  return neg ? v1 - v2 : v1 + v2;
            3'b111:  return {31'b0, (v1 == v2) ^ neg};
            default: return v1 ^ v2;
        endcase
    endfunction

    assign alu_res = tb_alu(alu_var1, alu_var2, alu_opt, alu_snpc, alu_negate);

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [1:0]  s1;
        logic        s2;
        logic [2:0]  opt;
        logic        snpc, ext, sign, neg;
        logic [1:0]  kind;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic op_t mk(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [1:0] s1, input logic s2,
                               input logic [2:0] opt, input logic snpc, input logic neg,
                               input logic [1:0] kind, input logic [4:0] rd);
        op_t o;
        o.pc = pc; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.s1 = s1; o.s2 = s2;
        o.opt = opt; o.snpc = snpc; o.neg = neg; o.kind = kind; o.rd = rd;
        o.ext = opt[1]; o.sign = rd[0];
        return o;
    endfunction

    function automatic exp_t mkx(input logic [31:0] data, input logic [4:0] rd,
                                 input logic redir, input logic [31:0] rpc);
        exp_t e;
        e.data = data; e.rd = rd; e.redir = redir; e.rpc = rpc;
        return e;
    endfunction

    // Transaction-level reference: what writeback and fetch should see for one op
    function automatic exp_t predict(input op_t o);
        exp_t        e;
        logic [31:0] v1, v2, r;
        v1 = (o.s1 == 2'd0) ? o.rs1 : (o.s1 == 2'd1) ? o.pc : 32'd0;
        v2 = o.s2 ? o.imm : o.rs2;
        r  = tb_alu(v1, v2, o.opt, o.snpc, o.neg);
        e.data = r; e.rd = o.rd; e.redir = 1'b0; e.rpc = 32'd0;
        case (o.kind)
            2'd1: begin e.data = 32'd0; e.rd = 5'd0; e.redir = r[0]; e.rpc = o.pc + o.imm; end
            2'd2: begin e.redir = 1'b1; e.rpc = o.pc + o.imm; end
            2'd3: begin e.redir = 1'b1; e.rpc = (o.rs1 + o.imm) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.pc   = $urandom & 32'hFFFF_FFFC;
        o.rs1  = $urandom;
        o.rs2  = ($urandom_range(0, 1) == 0) ? o.rs1 : $urandom;
        o.imm  = $urandom;
        o.kind = 2'($urandom_range(0, 3));
        o.s1   = 2'($urandom_range(0, 3));
        o.s2   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0:       o.opt = 3'b001;
            1:       o.opt = 3'b111;
            default: o.opt = 3'($urandom_range(0, 7));
        endcase
        o.snpc = 1'b0;
        if (o.kind >= 2'd2) begin o.snpc = 1'b1; o.s1 = 2'd1; end
        o.ext  = 1'($urandom_range(0, 1));
        o.sign = 1'($urandom_range(0, 1));
        o.neg  = 1'($urandom_range(0, 1));
        o.rd   = 5'($urandom_range(0, 31));
        return o;
    endfunction

    task automatic drive(input op_t o, input logic v);
        in_valid = v;
        in_pc = o.pc; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
        in_src1_sel = o.s1; in_src2_sel = o.s2; in_opt = o.opt;
        in_snpc = o.snpc; in_ext = o.ext; in_sign = o.sign; in_negate = o.neg;
        in_kind = o.kind; in_rd = o.rd;
    endtask

    vec_t        vecs[12];
    exp_t        q[$];
    op_t         cur, opa, opb;
    exp_t        ea, eb;
    logic        exec_flag, exp_ov, exp_rdy, acc, cpl;
    int unsigned exp_ops, exp_stall;

    initial begin
        vecs[0]  = '{mk(32'h0, 32'd5, 32'd7, 32'h0, 2'd0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 5'd3),
                     mkx(32'd12, 5'd3, 1'b0, 32'h0)};
        vecs[1]  = '{mk(32'h100, 32'd9, 32'd9, 32'h20, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, 2'd1, 5'd4),
                     mkx(32'h0, 5'd0, 1'b1, 32'h120)};
        vecs[2]  = '{mk(32'h100, 32'd9, 32'd8, 32'h20, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, 2'd1, 5'd4),
                     mkx(32'h0, 5'd0, 1'b0, 32'h0)};
        vecs[3]  = '{mk(32'h80, 32'h1003, 32'h0, 32'h4, 2'd1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd3, 5'd1),
                     mkx(32'h84, 5'd1, 1'b1, 32'h1006)};
        vecs[4]  = '{mk(32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 2'd1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd2, 5'd31),
                     mkx(32'hFFFF_FFF4, 5'd31, 1'b1, 32'h10)};
        vecs[5]  = '{mk(32'h0, 32'hDEAD, 32'h0, 32'h1234_5000, 2'd2, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 5'd2),
                     mkx(32'h1234_5000, 5'd2, 1'b0, 32'h0)};
        vecs[6]  = '{mk(32'h500, 32'hAAAA, 32'h0, 32'h77, 2'd3, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 5'd6),
                     mkx(32'h77, 5'd6, 1'b0, 32'h0)};
        vecs[7]  = '{mk(32'h0, 32'd5, 32'd7, 32'h0, 2'd0, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 5'd7),
                     mkx(32'hFFFF_FFFE, 5'd7, 1'b0, 32'h0)};
        vecs[8]  = '{mk(32'h1000, 32'h0, 32'h0, 32'h2000, 2'd1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 5'd8),
                     mkx(32'h3000, 5'd8, 1'b0, 32'h0)};
        vecs[9]  = '{mk(32'h200, 32'd1, 32'd2, 32'hFFFF_FFF0, 2'd0, 1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 5'd9),
                     mkx(32'h0, 5'd0, 1'b1, 32'h1F0)};
        vecs[10] = '{mk(32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 2'd0, 1'b0, 3'b100, 1'b0, 1'b0, 2'd0, 5'd10),
                     mkx(32'hFF00, 5'd10, 1'b0, 32'h0)};
        vecs[11] = '{mk(32'h10, 32'h0, 32'h0, 32'hFFFF_FFFF, 2'd1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd3, 5'd12),
                     mkx(32'h14, 5'd12, 1'b1, 32'hFFFF_FFFE)};

        // Reset state
        rst_n = 1'b0; out_ready = 1'b1;
        drive(vecs[0].op, 1'b0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redir_valid", redir_valid, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock); rst_n = 1'b1;

        // Directed vectors, out_ready held high
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clock);
            drive(vecs[i].op, 1'b1);
            #1 chk("vec_in_ready_idle", in_ready, 1);
            @(negedge clock);
            in_valid = 1'b0;
            chk("vec_exec_out_valid", out_valid, 0);
            chk("vec_exec_in_ready", in_ready, 0);
            chk("vec_exec_redir_valid", redir_valid, vecs[i].exp.redir);
            if (vecs[i].exp.redir) chk("vec_redir_pc", redir_pc, vecs[i].exp.rpc);
            chk("vec_alu_var2", alu_var2, vecs[i].op.s2 ? vecs[i].op.imm : vecs[i].op.rs2);
            chk("vec_alu_opt", alu_opt, vecs[i].op.opt);
            chk("vec_alu_ctl", {alu_snpc, alu_ext, alu_sign, alu_negate},
                {vecs[i].op.snpc, vecs[i].op.ext, vecs[i].op.sign, vecs[i].op.neg});
            @(negedge clock);
            chk("vec_hold_out_valid", out_valid, 1);
            chk("vec_out_data", out_data, vecs[i].exp.data);
            chk("vec_out_rd", out_rd, vecs[i].exp.rd);
            chk("vec_hold_redir_valid", redir_valid, 0);
        end

        // Backpressure in HOLD, then release with a new op accepted on the same edge
        opa = mk(32'h0, 32'd100, 32'd23, 32'h0, 2'd0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 5'd9);
        opb = mk(32'h300, 32'd40, 32'd2, 32'h0, 2'd0, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 5'd11);
        @(negedge clock); drive(opa, 1'b1);
        @(negedge clock); in_valid = 1'b0; out_ready = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 32'd123);
            chk("bp_out_rd", out_rd, 5'd9);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clock);
        chk("bp_out_data_last", out_data, 32'd123);
        out_ready = 1'b1; drive(opb, 1'b1);
        #1 chk("bp_release_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("bp_next_exec_out_valid", out_valid, 0);
        chk("bp_next_var1", alu_var1, 32'd40);
        @(negedge clock);
        chk("bp_next_out_valid", out_valid, 1);
        chk("bp_next_out_data", out_data, 32'd38);
        chk("bp_next_out_rd", out_rd, 5'd11);

        // Reset asserted while a jump is in EXEC
        opa = mk(32'h40, 32'h0, 32'h0, 32'h100, 2'd1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd2, 5'd5);
        @(negedge clock); drive(opa, 1'b1);
        @(negedge clock); in_valid = 1'b0;
        chk("rx_exec_redir_valid", redir_valid, 1);
        chk("rx_exec_redir_pc", redir_pc, 32'h140);
        #2 rst_n = 1'b0;
        #1;
        chk("rx_out_valid", out_valid, 0);
        chk("rx_redir_valid", redir_valid, 0);
        chk("rx_out_rd", out_rd, 0);
        chk("rx_out_data", out_data, 0);
        @(negedge clock); rst_n = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rx_after_out_valid", out_valid, 0);
            chk("rx_after_redir_valid", redir_valid, 0);
        end

        // Randomized traffic against the transaction model; counters restart here
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
        q.delete(); exec_flag = 1'b0; exp_ops = 0; exp_stall = 0;
        in_valid = 1'b0;
        for (int unsigned c = 0; c < 4000; c++) begin
            @(negedge clock);
            exp_ov = (q.size() != 0) && !exec_flag;
            chk("rnd_out_valid", out_valid, exp_ov);
            if (exec_flag) begin
                chk("rnd_redir_valid", redir_valid, q[0].redir);
                if (q[0].redir) chk("rnd_redir_pc", redir_pc, q[0].rpc);
            end else begin
                chk("rnd_redir_idle", redir_valid, 0);
            end
            if (exp_ov) begin
                chk("rnd_out_data", out_data, q[0].data);
                chk("rnd_out_rd", out_rd, q[0].rd);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                cur = rand_op();
                drive(cur, 1'b1);
            end
            #1;
            exp_rdy = (q.size() == 0) || (exp_ov && out_ready);
            chk("rnd_in_ready", in_ready, exp_rdy);
            acc = in_valid && exp_rdy;
            cpl = exp_ov && out_ready;
            if (cpl) exp_ops++;
            if (exp_ov && !out_ready) exp_stall++;
            @(posedge clock);
            #1;
            if (cpl) void'(q.pop_front());
            if (acc) begin
                q.push_back(predict(cur));
                in_valid = 1'b0;
            end
            exec_flag = acc;
        end
`ifdef YSYX_25040111_EXU_PERF_EN
        @(negedge clock);
        chk("perf_ops", perf_ops, exp_ops);
        chk("perf_stall", perf_stall, exp_stall);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_exu.md
YSYX_25040111_EXU -- requirements
Module: ysyx_25040111_exu

Interface
REQ-001 SHALL have ports, clock and reset first:
  clock  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid / in_ready  in / out  1 / 1  decode-side handshake
  in_pc, in_rs1, in_rs2, in_imm  in  32 each  pc, register operands, immediate
  in_src1_sel  in  2  var1 source: 0 rs1, 1 pc, 2 zero, 3 reserved (treated as zero)
  in_src2_sel  in  1  var2 source: 0 rs2, 1 imm
  in_opt  in  3  ALU opt
  in_snpc, in_ext, in_sign, in_negate  in  1 each  ALU controls
  in_kind  in  2  0 alu, 1 branch, 2 jal, 3 jalr
  in_rd  in  5  destination register
  alu_var1, alu_var2  out  32  operands to combinational ALU
  alu_opt  out  3  ALU opt
  alu_snpc, alu_ext, alu_sign, alu_negate  out  1 each  ALU controls
  alu_res  in  32  ALU result, same cycle
  out_valid / out_ready  out / in  1 / 1  writeback-side handshake
  out_rd  out  5  destination, 0 = no write
  out_data  out  32  writeback value
  redir_valid  out  1  one-cycle fetch redirect pulse
  redir_pc  out  32  redirect target
REQ-002 SHALL use one clock domain; rst_n SHALL be asynchronous, active-low.

Function
REQ-003 FSM states SHALL be IDLE, EXEC, HOLD.
REQ-004 in_ready SHALL be 1 in IDLE, 0 in EXEC, and equal to out_ready in HOLD.
REQ-005 On in_valid&&in_ready, all in_* fields SHALL be latched into an internal op register and the FSM SHALL enter EXEC.
REQ-006 alu_* outputs SHALL be driven combinationally from the op register only; var1/var2 selected per src sels.
REQ-007 In EXEC, result SHALL be captured into the output register and FSM SHALL enter HOLD with out_valid=1 next cycle.
REQ-008 Capture per kind: alu: out_data=alu_res, out_rd=rd; branch: out_rd=0, out_data=0; jal/jalr: out_data=alu_res (decode sets src1=pc, snpc=1, giving pc+4), out_rd=rd.
REQ-009 Redirect SHALL pulse redir_valid for exactly the EXEC cycle when: branch with alu_res[0]=1 (target pc+imm); jal (target pc+imm); jalr (target (rs1+imm)&~1). A local 32-bit adder SHALL compute targets; wrap modulo 2^32.
REQ-010 Branch not taken SHALL produce redir_valid=0.
REQ-011 In HOLD, out_* SHALL remain stable while out_ready=0.
REQ-012 In HOLD, on out_ready=1: out handshake completes; if in_valid=1 the new op SHALL be latched same edge and FSM enters EXEC (out_valid=0 next cycle); else FSM enters IDLE.
REQ-013 Throughput SHALL be one op per 2 cycles with out_ready held 1; latency from input handshake to out_valid SHALL be 2 cycles.
REQ-014 in_valid while in_ready=0 SHALL be ignored (upstream holds it).

Reset
REQ-015 rst_n low SHALL immediately force FSM=IDLE, out_valid=0, redir_valid=0, out_rd=0, out_data=0, op register cleared; in-flight op SHALL be discarded.
REQ-016 First acceptance after reset deassertion SHALL be at the first rising edge with in_valid=1.

Configuration
REQ-017 Macro YSYX_25040111_EXU_PERF_EN defined: SHALL add outputs perf_ops (32, completed out handshakes) and perf_stall (32, HOLD cycles with out_ready=0), both reset to 0, wrapping at 2^32.
REQ-018 Macro undefined: perf ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-019 ADD: src1=rs1=5, src2=rs2=7, opt=001, ext=0, out_ready=1 -> out_valid 2 cycles later, out_data=12, out_rd=rd, redir_valid=0.
REQ-020 BEQ taken: rs1=rs2=9, opt=111, negate=0, pc=0x100, imm=0x20 -> redir_valid=1 in EXEC, redir_pc=0x120, out_rd=0.
REQ-021 JALR: pc=0x80, rs1=0x1003, imm=0x4, snpc=1 src1=pc -> redir_pc=0x1006, out_data=0x84.
REQ-022 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0; release with in_valid=1 -> next op accepted same edge.
REQ-023 rst_n asserted during EXEC -> out_valid=0, redir_valid=0 immediately; no output after release.
REQ-024 PERF_EN build: 3 ops, 4 stall cycles -> perf_ops=3, perf_stall=4.
